count_seq_ctrl: RTL and testbench

//  Sequencing controller for the team's free-running up-counter datapath.
//  It turns that counter into a run-to-limit timer: start, pause and abort

---
 rtl/count_seq_ctrl_if.sv | 27 ++
 rtl/count_seq_ctrl.sv | 104 ++++++++++
 tb/tb_count_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_seq_ctrl_if.sv
// Host-facing command/status bundle for the run-to-limit counter sequencer.
// The host drives commands through master; the controller answers through slave.
interface count_seq_ctrl_if #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 4
);
    logic              start;
    logic              pause;
    logic              abort;
    logic              auto_reload;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  count;
    logic [1:0]        state;
    logic              busy;
    logic              done;
    logic [WRAP_W-1:0] wraps;

    modport master (
        output start, pause, abort, auto_reload, load_val,
        input  count, state, busy, done, wraps
    );

    modport slave (
        input  start, pause, abort, auto_reload, load_val,
        output count, state, busy, done, wraps
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Sequencer that turns a free-running up-counter into a run-to-limit timer with
// pause/abort, optional auto-reload, a one-cycle done pulse and a wrap tally.
module count_seq_ctrl #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    count_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  limit_q, limit_d;
    logic              mode_q, mode_d;
    logic              done_q, done_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            wraps_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            wraps_q <= wraps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        wraps_d = wraps_q;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (!bus.abort && bus.start) begin
                    limit_d = bus.load_val;
                    mode_d  = bus.auto_reload;
                    wraps_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Pause outranks the terminal check, so a pause at the limit
                // defers the done pulse until after the resume cycle.
                if (bus.abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (bus.pause) begin
                    state_d = PAUSE;
                end else if (count_q == limit_q) begin
                    done_d = 1'b1;
                    if (mode_q) begin
                        count_d = '0;
                        wraps_d = wraps_q + WRAP_W'(1);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            PAUSE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (!bus.pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign bus.count = count_q;
    assign bus.state = state_q;
    assign bus.busy  = (state_q == RUN) || (state_q == PAUSE);
    assign bus.done  = done_q;
    assign bus.wraps = wraps_q;
endmodule

// File: tb/tb_count_seq_ctrl.sv
// Randomized bench for count_seq_ctrl: expected per-cycle traces are built from
// the timer's rules (run length, pause window, reload period) and compared cycle by cycle.
module tb_count_seq_ctrl;
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;
    typedef logic [10:0] snap_t; // {state, count, done, busy, wraps}

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    count_seq_ctrl_if #(.WIDTH(3), .WRAP_W(4)) bus ();
    count_seq_ctrl #(.WIDTH(3), .WRAP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic snap_t mk(input logic [1:0] st, input int cnt, input logic dn, input int wr);
        logic [2:0] c3;
        logic [3:0] w4;
        c3 = cnt[2:0];
        w4 = wr[3:0];
        return {st, c3, dn, (st == S_RUN || st == S_PAUSE), w4};
    endfunction

    function automatic snap_t obs();
        return {bus.state, bus.count, bus.done, bus.busy, bus.wraps};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.pause = 0; bus.abort = 0; bus.auto_reload = 0; bus.load_val = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.start = 1; bus.load_val = 3'd6; // reset must beat a pending start
        rst = 1;
        tick(); tick();
        checks++;
        if (obs() !== mk(S_IDLE, 0, 0, 0)) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", obs(), mk(S_IDLE, 0, 0, 0));
        end
        rst = 0;
        bus.start = 0;
        tick();
        checks++;
        if (obs() !== mk(S_IDLE, 0, 0, 0)) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs(), mk(S_IDLE, 0, 0, 0));
        end
    endtask

    // Single-shot run: L+1 RUN cycles counting 0..L, one DONE cycle with done, then IDLE.
    task automatic test_single_run(input int lim);
        snap_t exp[$];
        for (int k = 0; k <= lim; k++) exp.push_back(mk(S_RUN, k, 0, 0));
        exp.push_back(mk(S_DONE, lim, 1, 0));
        exp.push_back(mk(S_IDLE, 0, 0, 0));
        exp.push_back(mk(S_IDLE, 0, 0, 0));
        bus.load_val = lim[2:0]; bus.auto_reload = 0; bus.start = 1;
        tick();
        bus.start = 0; bus.load_val = 3'($urandom); bus.auto_reload = 1'($urandom);
        foreach (exp[i]) begin
            if (i > 0) tick();
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL single_run L=%0d cyc=%0d got=%h exp=%h", lim, i, obs(), exp[i]);
            end
        end
        idle_inputs();
    endtask

    // Auto-reload: count = k mod (L+1), done when k is a positive multiple, wraps = k div (L+1).
    task automatic test_auto_reload(input int lim, input int ncyc);
        int wr;
        bus.load_val = lim[2:0]; bus.auto_reload = 1; bus.start = 1;
        tick();
        bus.start = 0; bus.auto_reload = 0;
        for (int k = 0; k <= ncyc; k++) begin
            snap_t e;
            if (k > 0) tick();
            e = mk(S_RUN, k % (lim + 1), (k > 0) && (k % (lim + 1) == 0), (k / (lim + 1)) % 16);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL auto_reload L=%0d k=%0d got=%h exp=%h", lim, k, obs(), e);
            end
        end
        wr = (ncyc / (lim + 1)) % 16;
        bus.abort = 1;
        tick();
        bus.abort = 0;
        checks++;
        if (obs() !== mk(S_IDLE, 0, 0, wr)) begin
            failures++;
            $display("FAIL auto_abort L=%0d got=%h exp=%h", lim, obs(), mk(S_IDLE, 0, 0, wr));
        end
    endtask

    // Pause sampled at count p for n edges; starts fired during the window must be ignored.
    task automatic test_pause(input int lim, input int p, input int n);
        snap_t exp[$];
        for (int k = 0; k <= p; k++) exp.push_back(mk(S_RUN, k, 0, 0));
        for (int k = 0; k < n; k++) exp.push_back(mk(S_PAUSE, p, 0, 0));
        for (int k = p; k <= lim; k++) exp.push_back(mk(S_RUN, k, 0, 0));
        exp.push_back(mk(S_DONE, lim, 1, 0));
        exp.push_back(mk(S_IDLE, 0, 0, 0));
        bus.load_val = lim[2:0]; bus.auto_reload = 0; bus.start = 1;
        tick();
        bus.start = 0;
        foreach (exp[i]) begin
            if (i > 0) tick();
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL pause L=%0d p=%0d n=%0d cyc=%0d got=%h exp=%h", lim, p, n, i, obs(), exp[i]);
            end
            bus.pause = (i >= p) && (i < p + n);
            bus.start = bus.pause;
            bus.auto_reload = 1;
            bus.load_val = 3'($urandom);
        end
        idle_inputs();
    endtask

    task automatic test_abort(input int lim, input int a);
        bus.load_val = lim[2:0]; bus.start = 1;
        tick();
        bus.start = 0;
        for (int k = 0; k <= a; k++) begin
            if (k > 0) tick();
            checks++;
            if (obs() !== mk(S_RUN, k, 0, 0)) begin
                failures++;
                $display("FAIL abort_run L=%0d k=%0d got=%h exp=%h", lim, k, obs(), mk(S_RUN, k, 0, 0));
            end
        end
        bus.abort = 1; bus.pause = 1'($urandom);
        tick();
        bus.abort = 0; bus.pause = 0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) tick();
            checks++;
            if (obs() !== mk(S_IDLE, 0, 0, 0)) begin
                failures++;
                $display("FAIL abort_idle L=%0d a=%0d got=%h exp=%h", lim, a, obs(), mk(S_IDLE, 0, 0, 0));
            end
        end
    endtask

    task automatic test_abort_misc();
        // abort while paused, pause still high
        bus.load_val = 3'd5; bus.start = 1;
        tick();
        bus.start = 0; bus.pause = 1;
        tick();
        checks++;
        if (obs() !== mk(S_PAUSE, 0, 0, 0)) begin
            failures++;
            $display("FAIL abort_pause_enter got=%h exp=%h", obs(), mk(S_PAUSE, 0, 0, 0));
        end
        bus.abort = 1;
        tick();
        bus.abort = 0; bus.pause = 0;
        checks++;
        if (obs() !== mk(S_IDLE, 0, 0, 0)) begin
            failures++;
            $display("FAIL abort_pause got=%h exp=%h", obs(), mk(S_IDLE, 0, 0, 0));
        end
        // start together with abort in IDLE stays IDLE
        bus.start = 1; bus.abort = 1; bus.load_val = 3'd4;
        tick();
        idle_inputs();
        checks++;
        if (obs() !== mk(S_IDLE, 0, 0, 0)) begin
            failures++;
            $display("FAIL start_abort_idle got=%h exp=%h", obs(), mk(S_IDLE, 0, 0, 0));
        end
    endtask

    task automatic test_reset_midrun();
        // auto-reload L=4: k=13 is wrap 2, count 3
        bus.load_val = 3'd4; bus.auto_reload = 1; bus.start = 1;
        tick();
        idle_inputs();
        repeat (13) tick();
        checks++;
        if (obs() !== mk(S_RUN, 3, 0, 2)) begin
            failures++;
            $display("FAIL midrun_pre got=%h exp=%h", obs(), mk(S_RUN, 3, 0, 2));
        end
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (obs() !== mk(S_IDLE, 0, 0, 0)) begin
            failures++;
            $display("FAIL midrun_rst got=%h exp=%h", obs(), mk(S_IDLE, 0, 0, 0));
        end
        // reset on the terminal edge of a single-shot run suppresses done
        bus.load_val = 3'd2; bus.start = 1;
        tick();
        bus.start = 0;
        tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (obs() !== mk(S_IDLE, 0, 0, 0)) begin
            failures++;
            $display("FAIL terminal_rst got=%h exp=%h", obs(), mk(S_IDLE, 0, 0, 0));
        end
    endtask

    // Starts in RUN and in DONE are dropped; the original limit/mode stay in force.
    task automatic test_start_ignored();
        snap_t exp[$];
        for (int k = 0; k <= 6; k++) exp.push_back(mk(S_RUN, k, 0, 0));
        exp.push_back(mk(S_DONE, 6, 1, 0));
        exp.push_back(mk(S_IDLE, 0, 0, 0));
        exp.push_back(mk(S_IDLE, 0, 0, 0));
        bus.load_val = 3'd6; bus.auto_reload = 0; bus.start = 1;
        tick();
        bus.start = 0;
        foreach (exp[i]) begin
            if (i > 0) tick();
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL start_ignored cyc=%0d got=%h exp=%h", i, obs(), exp[i]);
            end
            bus.start = (i == 2) || (i == 3) || (i == 7);
            bus.load_val = 3'd1;
            bus.auto_reload = 1;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_single_run(5);
        test_single_run(0);
        test_single_run(7);
        repeat (4) test_single_run(int'($urandom_range(0, 7)));
        test_auto_reload(7, 24);
        test_auto_reload(0, 20);
        repeat (3) test_auto_reload(int'($urandom_range(0, 7)), int'($urandom_range(5, 40)));
        test_single_run(3); // start after auto-reload clears wraps
        test_pause(6, 2, 3);
        repeat (4) begin
            int l, p;
            l = int'($urandom_range(1, 7));
            p = int'($urandom_range(0, l));
            test_pause(l, p, int'($urandom_range(1, 4)));
        end
        test_abort(6, 4);
        repeat (3) begin
            int l;
            l = int'($urandom_range(0, 7));
            test_abort(l, int'($urandom_range(0, l)));
        end
        test_abort_misc();
        test_single_run(0);
        test_reset_midrun();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
